// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage: instruction width,
// the opcodes the fetch stage cares about, and the fetch FSM encoding.
package fetch_unit_pkg;

  localparam int INSTR_W = 16;

  localparam logic [4:0] OPC_HALT = 5'b00000;
  localparam logic [4:0] OPC_NOP  = 5'b00001;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // True when the instruction word carries the HALT opcode in its top five bits.
  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 5] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg
// One-entry output register between fetch and decode.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            capture load_instr / load_pc_plus2 this cycle
//   squash          discard the held entry (redirect); wins over load
//   stall           decode cannot accept; hold the current entry
//   load_instr      instruction word to capture
//   load_pc_plus2   fetch address + 2 of load_instr
//   instr           held instruction, NOP_INSTR when empty
//   pc_plus2        held fetch address + 2
//   instr_valid     entry is valid
module fetch_out_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = {OPC_NOP, 11'd0}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               squash,
  input  logic               stall,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [INSTR_W-1:0] load_pc_plus2,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc_plus2,
  output logic               instr_valid
);

  // Squash beats load; an entry consumed without a replacement reverts to
  // a NOP so decode never sees stale instruction bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr       <= NOP_INSTR;
      pc_plus2    <= '0;
      instr_valid <= 1'b0;
    end else if (squash) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= load_instr;
      pc_plus2    <= load_pc_plus2;
      instr_valid <= 1'b1;
    end else if (instr_valid && !stall) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage: owns the PC, issues word fetches to a
// variable-latency memory, hands instructions to decode through a one-entry
// output register, handles redirects (draining in-flight fetches) and HALT.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   stall           decode cannot accept
//   redirect        one-cycle branch/jump pulse; redirect_pc is the target
//   imem_req        fetch request, imem_addr its (even) address
//   imem_rdy        memory response valid, imem_data the instruction word
//   instr           instruction to decode, pc_plus2 its fetch address + 2
//   instr_valid     instr / pc_plus2 are valid
//   halted          fetch has stopped on a HALT
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {OPC_NOP, 11'd0}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc_plus2,
  output logic               instr_valid,
  output logic               halted
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] addr_q;
  logic               pending_q;
  logic               active;

  logic               slot_free;
  logic               fetch_req;
  logic               accept;
  logic [INSTR_W-1:0] next_addr;
  logic [INSTR_W-1:0] target_pc;

  assign target_pc = redirect_pc & 16'hFFFE;
  assign slot_free = !instr_valid || !stall;

  // 'active' keeps the request low while reset is held and drops it the
  // instant reset asserts. Once presented, pending_q holds a request up
  // until the memory answers, even if decode stalls meanwhile.
  assign fetch_req = active && (slot_free || pending_q);
  assign imem_req  = (state == FETCH) ? fetch_req : (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? addr_q : pc;
  assign next_addr = imem_addr + 16'd2;

  assign accept = (state == FETCH) && imem_req && imem_rdy && slot_free && !redirect;

  // FSM and next-PC selection. Redirect outranks everything; a redirect that
  // catches a request still waiting on memory must drain that response first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      addr_q    <= RESET_PC;
      pending_q <= 1'b0;
      active    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      active <= 1'b1;
      if (imem_req) begin
        addr_q <= imem_addr;
      end
      if (redirect) begin
        pc        <= target_pc;
        pending_q <= 1'b0;
        halted    <= 1'b0;
        case (state)
          FETCH:   state <= (imem_req && !imem_rdy) ? DRAIN : FETCH;
          DRAIN:   state <= imem_rdy ? FETCH : DRAIN;
          default: state <= FETCH;
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (accept) begin
              pc        <= next_addr;
              pending_q <= 1'b0;
              if (is_halt(imem_data)) begin
                state  <= HALTED;
                halted <= 1'b1;
              end
            end else begin
              pending_q <= imem_req;
            end
          end
          DRAIN: begin
            if (imem_rdy) begin
              state     <= FETCH;
              pending_q <= 1'b0;
            end
          end
          default: begin
            state <= HALTED;
          end
        endcase
      end
    end
  end

  fetch_out_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .squash       (redirect),
    .stall        (stall),
    .load_instr   (imem_data),
    .load_pc_plus2(next_addr),
    .instr        (instr),
    .pc_plus2     (pc_plus2),
    .instr_valid  (instr_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit with a behavioural instruction memory whose
// wait-cycle count is set per scenario. The memory returns {1'b1, addr[15:1]}
// for every address except halt_addr, which returns the HALT word 16'h0000.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        halted;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          wait_n       = 0;
  int          wcnt;
  logic [15:0] halt_addr    = 16'h0001;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_data  (imem_data),
    .instr      (instr),
    .pc_plus2   (pc_plus2),
    .instr_valid(instr_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Memory model: answers after wait_n cycles of a held request.
  assign imem_rdy  = imem_req && (wcnt >= wait_n);
  assign imem_data = (imem_addr == halt_addr) ? 16'h0000 : {1'b1, imem_addr[15:1]};

  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (!imem_req || imem_rdy) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset two cycles, then releases just after an edge; the next
  // rising edge is the first one out of reset.
  task automatic do_reset(input int waits, input logic [15:0] haddr);
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    wait_n      = waits;
    halt_addr   = haddr;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    tick();
    n_compared++; if (imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
    n_compared++; if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_valid: got %b want 0", instr_valid); end
    n_compared++; if (instr !== 16'h0800) begin n_mismatched++; $display("[TB] FAIL rst_instr: got %h want 0800", instr); end
    n_compared++; if (pc_plus2 !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL rst_pc_plus2: got %h want 0000", pc_plus2); end
    n_compared++; if (halted !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_halted: got %b want 0", halted); end
  endtask

  task automatic test_zero_wait();
    logic [15:0] exp_addr  [3] = '{16'h0002, 16'h0004, 16'h0006};
    logic [15:0] exp_pp2   [3] = '{16'h0002, 16'h0004, 16'h0006};
    logic [15:0] exp_instr [3] = '{16'h8000, 16'h8001, 16'h8002};
    do_reset(0, 16'h0001);
    tick();
    n_compared++; if (imem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zw_first_req: got %b want 1", imem_req); end
    n_compared++; if (imem_addr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL zw_first_addr: got %h want 0000", imem_addr); end
    n_compared++; if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zw_first_valid: got %b want 0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_compared++; if (instr_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zw_valid[%0d]: got %b want 1", k, instr_valid); end
      n_compared++; if (pc_plus2 !== exp_pp2[k]) begin n_mismatched++; $display("[TB] FAIL zw_pc_plus2[%0d]: got %h want %h", k, pc_plus2, exp_pp2[k]); end
      n_compared++; if (instr !== exp_instr[k]) begin n_mismatched++; $display("[TB] FAIL zw_instr[%0d]: got %h want %h", k, instr, exp_instr[k]); end
      n_compared++; if (imem_addr !== exp_addr[k]) begin n_mismatched++; $display("[TB] FAIL zw_addr[%0d]: got %h want %h", k, imem_addr, exp_addr[k]); end
    end
  endtask

  task automatic test_wait_stall();
    do_reset(3, 16'h0001);
    tick(); tick(); tick(); tick();
    n_compared++; if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_early_valid: got %b want 0", instr_valid); end
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_compared++; if (imem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_stall_req[%0d]: got %b want 0", k, imem_req); end
      n_compared++; if ({instr_valid, instr, pc_plus2} !== {1'b1, 16'h8000, 16'h0002}) begin n_mismatched++; $display("[TB] FAIL ws_hold[%0d]: got %b/%h/%h want 1/8000/0002", k, instr_valid, instr, pc_plus2); end
    end
    stall = 1'b0;
    #1;
    n_compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin n_mismatched++; $display("[TB] FAIL ws_resume_req: got %b/%h want 1/0002", imem_req, imem_addr); end
    tick();
    n_compared++; if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_consumed_valid: got %b want 0", instr_valid); end
    n_compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin n_mismatched++; $display("[TB] FAIL ws_held_req: got %b/%h want 1/0002", imem_req, imem_addr); end
    tick(); tick();
    n_compared++; if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ws_wait2_valid: got %b want 0", instr_valid); end
    tick();
    n_compared++; if ({instr_valid, instr, pc_plus2} !== {1'b1, 16'h8001, 16'h0004}) begin n_mismatched++; $display("[TB] FAIL ws_second: got %b/%h/%h want 1/8001/0004", instr_valid, instr, pc_plus2); end
  endtask

  task automatic test_redirect_drain();
    do_reset(3, 16'h0001);
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    #1;
    n_compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0010}) begin n_mismatched++; $display("[TB] FAIL rd_start: got %b/%h want 1/0010", imem_req, imem_addr); end
    tick();
    redirect = 1'b1; redirect_pc = 16'h0041;
    tick();
    redirect = 1'b0;
    #1;
    n_compared++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0010, 1'b0}) begin n_mismatched++; $display("[TB] FAIL rd_drain: got %b/%h/%b want 1/0010/0", imem_req, imem_addr, instr_valid); end
    tick();
    n_compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0010}) begin n_mismatched++; $display("[TB] FAIL rd_drain_hold: got %b/%h want 1/0010", imem_req, imem_addr); end
    tick();
    n_compared++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0040, 1'b0}) begin n_mismatched++; $display("[TB] FAIL rd_target_req: got %b/%h/%b want 1/0040/0", imem_req, imem_addr, instr_valid); end
    tick(); tick(); tick();
    n_compared++; if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rd_wait_valid: got %b want 0", instr_valid); end
    tick();
    n_compared++; if ({instr_valid, instr, pc_plus2} !== {1'b1, 16'h8020, 16'h0042}) begin n_mismatched++; $display("[TB] FAIL rd_target_data: got %b/%h/%h want 1/8020/0042", instr_valid, instr, pc_plus2); end
  endtask

  task automatic test_halt();
    int req_seen;
    do_reset(0, 16'h0020);
    redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    redirect = 1'b0;
    #1;
    n_compared++; if (imem_addr !== 16'h0020) begin n_mismatched++; $display("[TB] FAIL ht_addr: got %h want 0020", imem_addr); end
    tick();
    n_compared++; if ({instr_valid, instr, pc_plus2} !== {1'b1, 16'h0000, 16'h0022}) begin n_mismatched++; $display("[TB] FAIL ht_deliver: got %b/%h/%h want 1/0000/0022", instr_valid, instr, pc_plus2); end
    n_compared++; if ({halted, imem_req} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL ht_halted: got halted=%b req=%b want 1/0", halted, imem_req); end
    req_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (imem_req) req_seen++;
    end
    n_compared++; if (req_seen !== 0) begin n_mismatched++; $display("[TB] FAIL ht_idle_req: got %0d request cycles want 0", req_seen); end
    n_compared++; if ({halted, instr_valid, instr} !== {1'b1, 1'b0, 16'h0800}) begin n_mismatched++; $display("[TB] FAIL ht_idle_state: got %b/%b/%h want 1/0/0800", halted, instr_valid, instr); end
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    #1;
    n_compared++; if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0100}) begin n_mismatched++; $display("[TB] FAIL ht_resume: got %b/%b/%h want 0/1/0100", halted, imem_req, imem_addr); end
    tick();
    n_compared++; if ({instr_valid, instr, pc_plus2} !== {1'b1, 16'h8080, 16'h0102}) begin n_mismatched++; $display("[TB] FAIL ht_resume_data: got %b/%h/%h want 1/8080/0102", instr_valid, instr, pc_plus2); end
  endtask

  task automatic test_wrap();
    do_reset(0, 16'h0001);
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    #1;
    n_compared++; if (imem_addr !== 16'hFFFE) begin n_mismatched++; $display("[TB] FAIL wr_addr: got %h want FFFE", imem_addr); end
    tick();
    n_compared++; if ({instr_valid, instr, pc_plus2} !== {1'b1, 16'hFFFF, 16'h0000}) begin n_mismatched++; $display("[TB] FAIL wr_data: got %b/%h/%h want 1/FFFF/0000", instr_valid, instr, pc_plus2); end
    n_compared++; if (imem_addr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL wr_next_addr: got %h want 0000", imem_addr); end
  endtask

  task automatic test_reset_midflight();
    do_reset(0, 16'h0001);
    tick(); tick(); tick();
    n_compared++; if ({imem_req, instr_valid} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL rm_pre: got req=%b valid=%b want 1/1", imem_req, instr_valid); end
    rst = 1'b0;
    #1;
    n_compared++; if ({imem_req, instr_valid, instr, pc_plus2} !== {1'b0, 1'b0, 16'h0800, 16'h0000}) begin n_mismatched++; $display("[TB] FAIL rm_async: got %b/%b/%h/%h want 0/0/0800/0000", imem_req, instr_valid, instr, pc_plus2); end
    tick();
    rst = 1'b1;
    tick();
    n_compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin n_mismatched++; $display("[TB] FAIL rm_restart: got %b/%h want 1/0000", imem_req, imem_addr); end
    tick();
    n_compared++; if ({instr_valid, pc_plus2} !== {1'b1, 16'h0002}) begin n_mismatched++; $display("[TB] FAIL rm_first: got %b/%h want 1/0002", instr_valid, pc_plus2); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_stall();
    test_redirect_drain();
    test_halt();
    test_wrap();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
